// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the fetch unit, the control decoder and the ALU.
//   fetch_state_t      : fetch FSM states BOOT / RUN / HALT
//   OPC_NOP / OPC_HALT : reserved opcodes (no-op filler and stop-fetch)
//   STAT_Z..STAT_V     : bit positions inside the 4-bit status register {V,C,N,Z}
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [6:0] OPC_NOP  = 7'b1111110;
  localparam logic [6:0] OPC_HALT = 7'b1111111;

  localparam int STAT_Z = 0;
  localparam int STAT_N = 1;
  localparam int STAT_C = 2;
  localparam int STAT_V = 3;

endpackage : cpu_pkg

// File: rtl/fetch_unit_pc_reg.sv
// pc_reg: program counter with load / increment / hold.
//   clk, rst_n  : clock, asynchronous active-low reset (PC resets to 0)
//   load_i      : load load_val_i (has priority over inc_i)
//   load_val_i  : jump target
//   inc_i       : advance PC by one, wrapping modulo 2^PC_W
//   pc_o        : current PC
//   wrap_o      : PC sits at the last address, so an increment now would wrap
module pc_reg #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [PC_W-1:0] load_val_i,
  input  logic            inc_i,
  output logic [PC_W-1:0] pc_o,
  output logic            wrap_o
);

  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    // NOTE: default assigned first so every path drives pc_d and no latch is inferred.
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values, whatever the block order.
      pc_q <= pc_d;
    end
  end

  assign pc_o   = pc_q;
  assign wrap_o = &pc_q;

endmodule : pc_reg

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the A/B accumulator CPU.
//   clk, rst_n          : clock, asynchronous active-low reset
//   stall               : freeze PC, IR, status and FSM for this cycle
//   ld_pc               : control's LP; jump to the literal held in the IR
//   imem_addr/imem_data : instruction ROM address (= PC) and its combinational word
//   opcode/literal      : IR fields; opcode reads NOP_OPC whenever the IR is not live
//   ir_pc, ir_valid     : fetch address of the IR word, IR-live flag
//   alu_flags, flags_we : {V,C,N,Z} from the ALU and its write enable
//   status              : status register read back by control
//   halted              : fetch stopped; only reset leaves this state
// Build option FETCH_WRAP_HALT_EN: a sequential fetch past the last ROM address
// halts instead of wrapping to 0 (the last word is still fetched and executed).
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              OPC_W    = 7,
  parameter int              LIT_W    = 8,
  parameter logic [OPC_W-1:0] NOP_OPC  = OPC_NOP,
  parameter logic [OPC_W-1:0] HALT_OPC = OPC_HALT,
  localparam int             INSTR_W  = OPC_W + LIT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               ld_pc,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [OPC_W-1:0]   opcode,
  output logic [LIT_W-1:0]   literal,
  output logic [PC_W-1:0]    ir_pc,
  output logic               ir_valid,
  input  logic [3:0]         alu_flags,
  input  logic               flags_we,
  output logic [3:0]         status,
  output logic               halted
);

`ifdef FETCH_WRAP_HALT_EN
  localparam bit WrapHaltEn = 1'b1;
`else
  localparam bit WrapHaltEn = 1'b0;
`endif

  fetch_state_t     state_q, state_d;
  logic [OPC_W-1:0] ir_opc_q, ir_opc_d;
  logic [LIT_W-1:0] ir_lit_q, ir_lit_d;
  logic [PC_W-1:0]  ir_pc_q, ir_pc_d;
  logic             ir_valid_q, ir_valid_d;
  logic [3:0]       status_q, status_d;
  // Set once the last address has been fetched; the next executed edge halts.
  logic             wrap_pend_q, wrap_pend_d;

  logic             pc_load, pc_inc, pc_at_max;
  logic [PC_W-1:0]  pc;

  pc_reg #(.PC_W(PC_W)) u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (pc_load),
    .load_val_i (ir_lit_q[PC_W-1:0]),
    .inc_i      (pc_inc),
    .pc_o       (pc),
    .wrap_o     (pc_at_max)
  );

  always_comb begin
    state_d     = state_q;
    ir_opc_d    = ir_opc_q;
    ir_lit_d    = ir_lit_q;
    ir_pc_d     = ir_pc_q;
    ir_valid_d  = ir_valid_q;
    status_d    = status_q;
    wrap_pend_d = wrap_pend_q;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;

    unique case (state_q)
      BOOT: state_d = RUN;

      RUN: begin
        if (!stall) begin
          if (flags_we && ir_valid_q) status_d = alu_flags;

          if (ir_valid_q && ir_opc_q == HALT_OPC) begin
            state_d    = HALT;
            ir_valid_d = 1'b0;
          end else if (ld_pc && ir_valid_q) begin
            // The word fetched behind the jump is wrong-path: drop it (one bubble).
            pc_load     = 1'b1;
            ir_valid_d  = 1'b0;
            wrap_pend_d = 1'b0;
          end else if (wrap_pend_q) begin
            state_d    = HALT;
            ir_valid_d = 1'b0;
          end else begin
            ir_opc_d   = imem_data[INSTR_W-1 -: OPC_W];
            ir_lit_d   = imem_data[LIT_W-1:0];
            ir_pc_d    = pc;
            ir_valid_d = 1'b1;
            if (WrapHaltEn && pc_at_max) wrap_pend_d = 1'b1;
            else                         pc_inc      = 1'b1;
          end
        end
      end

      default: ;  // HALT: frozen until reset
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      ir_opc_q    <= NOP_OPC;
      ir_lit_q    <= '0;
      ir_pc_q     <= '0;
      ir_valid_q  <= 1'b0;
      status_q    <= '0;
      wrap_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_opc_q    <= ir_opc_d;
      ir_lit_q    <= ir_lit_d;
      ir_pc_q     <= ir_pc_d;
      ir_valid_q  <= ir_valid_d;
      status_q    <= status_d;
      wrap_pend_q <= wrap_pend_d;
    end
  end

  assign imem_addr = pc;
  assign opcode    = ir_valid_q ? ir_opc_q : NOP_OPC;
  assign literal   = ir_lit_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;
  assign status    = status_q;
  assign halted    = (state_q == HALT);

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal expectations
// plus a long randomized run, all compared every cycle against a reference model.
module tb_fetch_unit;
  import cpu_pkg::*;

`ifdef FETCH_WRAP_HALT_EN
  localparam bit WRAP_HALT = 1'b1;
`else
  localparam bit WRAP_HALT = 1'b0;
`endif

  localparam logic [6:0] OPC_MOV_AK = 7'b0000010;
  localparam logic [6:0] OPC_ADD_AK = 7'b0000100;
  localparam logic [6:0] OPC_JMP    = 7'b0100000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, ld_pc = 1'b0, flags_we = 1'b0;
  logic [3:0]  alu_flags = 4'h0;
  logic [7:0]  imem_addr;
  logic [14:0] imem_data;
  logic [6:0]  opcode;
  logic [7:0]  literal, ir_pc;
  logic        ir_valid, halted;
  logic [3:0]  status;

  logic [14:0] rom [256];
  assign imem_data = rom[imem_addr];

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .ld_pc(ld_pc),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .opcode(opcode), .literal(literal), .ir_pc(ir_pc), .ir_valid(ir_valid),
    .alu_flags(alu_flags), .flags_we(flags_we), .status(status), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural view of the fetch stage.
  int         m_pc;
  logic [6:0] m_opc;
  logic [7:0] m_lit;
  int         m_irpc;
  bit         m_valid, m_boot, m_halted, m_last_fetched;
  logic [3:0] m_status;

  function automatic void model_reset();
    m_pc = 0; m_opc = OPC_NOP; m_lit = 8'h00; m_irpc = 0;
    m_valid = 0; m_boot = 1; m_halted = 0; m_last_fetched = 0; m_status = 4'h0;
  endfunction

  function automatic void model_edge();
    if (m_boot) begin
      m_boot = 0;
    end else if (!m_halted && !stall) begin
      if (flags_we && m_valid) m_status = alu_flags;
      if (m_valid && m_opc == OPC_HALT) begin
        m_halted = 1; m_valid = 0;
      end else if (ld_pc && m_valid) begin
        m_pc = int'(m_lit) % 256; m_valid = 0; m_last_fetched = 0;
      end else if (m_last_fetched) begin
        m_halted = 1; m_valid = 0;
      end else begin
        m_opc = rom[m_pc][14:8]; m_lit = rom[m_pc][7:0];
        m_irpc = m_pc; m_valid = 1;
        if (WRAP_HALT && m_pc == 255) m_last_fetched = 1;
        else m_pc = (m_pc + 1) % 256;
      end
    end
  endfunction

  // Single compare process: every negedge, all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("imem_addr", 32'(imem_addr), 32'(m_pc));
      check("ir_valid", 32'(ir_valid), 32'(m_valid));
      check("opcode", 32'(opcode), 32'(m_valid ? m_opc : OPC_NOP));
      if (m_valid) begin
        check("literal", 32'(literal), 32'(m_lit));
        check("ir_pc", 32'(ir_pc), 32'(m_irpc));
      end
      check("status", 32'(status), 32'(m_status));
      check("halted", 32'(halted), 32'(m_halted));
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Assert reset mid-cycle (asynchronously), release before the next edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    stall = 0; ld_pc = 0; flags_we = 0; alu_flags = 4'h0;
    #1;
    check("rst_async_addr", 32'(imem_addr), 32'h0);
    check("rst_async_halted", 32'(halted), 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic fill_rom_plain();
    for (int i = 0; i < 256; i++)
      rom[i] = {7'($urandom_range(0, 125)), 8'($urandom)};
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fill_rom_plain();
    model_reset();
    #7;
    cmp_en = 1'b1;

    // 1. Boot sequence and first fetches.
    rom[0] = {OPC_MOV_AK, 8'd5};
    rom[1] = {OPC_ADD_AK, 8'd1};
    rom[2] = {OPC_ADD_AK, 8'd2};
    rom[3] = {OPC_ADD_AK, 8'd3};
    do_reset();
    check("t1_boot_valid", 32'(ir_valid), 32'h0);
    check("t1_boot_opcode", 32'(opcode), 32'(7'b1111110));
    check("t1_reset_literal", 32'(literal), 32'h0);
    cycle();
    check("t1_boot_edge_valid", 32'(ir_valid), 32'h0);
    cycle();
    check("t1_first_opcode", 32'(opcode), 32'(7'b0000010));
    check("t1_first_literal", 32'(literal), 32'd5);
    check("t1_ir_pc0", 32'(ir_pc), 32'd0);
    cycle();
    check("t1_ir_pc1", 32'(ir_pc), 32'd1);
    cycle();
    check("t1_ir_pc2", 32'(ir_pc), 32'd2);

    // 2. Taken jump: one bubble, then the target word.
    rom[0] = {OPC_JMP, 8'h20};
    do_reset();
    cycle(); cycle();
    check("t2_jmp_literal", 32'(literal), 32'h20);
    ld_pc = 1;
    cycle();
    ld_pc = 0;
    check("t2_target_addr", 32'(imem_addr), 32'h20);
    check("t2_bubble", 32'(ir_valid), 32'h0);
    cycle();
    check("t2_target_ir_pc", 32'(ir_pc), 32'h20);
    check("t2_target_valid", 32'(ir_valid), 32'h1);

    // 3. Stall beats ld_pc and flags_we.
    rom[0] = {OPC_JMP, 8'h30};
    do_reset();
    cycle(); cycle();
    stall = 1; ld_pc = 1; flags_we = 1; alu_flags = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t3_stall_addr", 32'(imem_addr), 32'h1);
      check("t3_stall_ir_pc", 32'(ir_pc), 32'h0);
      check("t3_stall_status", 32'(status), 32'h0);
    end
    stall = 0;
    cycle();
    ld_pc = 0; flags_we = 0;
    check("t3_jump_addr", 32'(imem_addr), 32'h30);
    check("t3_status", 32'(status), 32'b1010);

    // 4. HALT at ROM[4], then asynchronous reset out of HALT.
    rom[0] = {OPC_MOV_AK, 8'd1};
    rom[4] = {OPC_HALT, 8'h00};
    do_reset();
    for (int i = 0; i < 7; i++) cycle();
    check("t4_halted", 32'(halted), 32'h1);
    check("t4_addr_frozen", 32'(imem_addr), 32'h5);
    check("t4_opcode_nop", 32'(opcode), 32'(7'b1111110));
    cycle(); cycle();
    check("t4_still_halted", 32'(halted), 32'h1);
    check("t4_still_addr", 32'(imem_addr), 32'h5);
    do_reset();
    check("t4_after_reset_addr", 32'(imem_addr), 32'h0);
    rom[4] = {OPC_ADD_AK, 8'h04};

    // 5. Status write gated by ir_valid.
    do_reset();
    flags_we = 1; alu_flags = 4'b0101;
    cycle();
    check("t5_boot_status", 32'(status), 32'h0);
    cycle();
    check("t5_invalid_status", 32'(status), 32'h0);
    cycle();
    check("t5_valid_status", 32'(status), 32'b0101);
    flags_we = 0;

    // 6. Straight-line run across the top of the address space.
    begin
      int budget;
      budget = 0;
      do_reset();
      while (!(m_valid && m_irpc == 255) && budget < 400) begin
        cycle();
        budget++;
      end
      check("t6_reached_ff", 32'(ir_pc), 32'hFF);
      cycle();
      if (WRAP_HALT) begin
        check("t6_wrap_halted", 32'(halted), 32'h1);
      end else begin
        check("t6_wrap_ir_pc", 32'(ir_pc), 32'h00);
        check("t6_wrap_halted", 32'(halted), 32'h0);
      end
    end

    // 7. Randomized run, including HALT words and occasional resets.
    for (int i = 0; i < 256; i++)
      rom[i] = ($urandom_range(0, 39) == 0) ? {OPC_HALT, 8'($urandom)}
                                            : {7'($urandom_range(0, 126)), 8'($urandom)};
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      stall     = ($urandom_range(0, 3) == 0);
      ld_pc     = ($urandom_range(0, 4) == 0) && !(m_valid && m_opc == OPC_HALT);
      flags_we  = 1'($urandom_range(0, 1));
      alu_flags = 4'($urandom_range(0, 15));
      if ((m_halted && $urandom_range(0, 5) == 0) || $urandom_range(0, 499) == 0)
        do_reset();
      else
        cycle();
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fetch_unit
